// File: rtl/blink_pkg.sv
// Shared types and default thresholds for the blink rate meter; the defaults
// track the LED blinker's step settings so fast/slow agree on both sides.
package blink_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    STALL   = 2'd2
  } state_t;

  localparam int CNT_W_DEF    = 27;
  localparam int FAST_MAX_DEF = 1000;
  localparam int TIMEOUT_DEF  = 50000000;

endpackage

// File: rtl/blink_edge_filter.sv
// Synchronizes blink_in, rejects pulses shorter than MIN_PULSE cycles and
// emits a one-cycle strobe on every accepted level change.
module blink_edge_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_PULSE   = 4
) (
  input  logic CLOCK_50,
  input  logic RESET,
  input  logic blink_in,
  output logic level,
  output logic edge_pulse
);

  localparam int RUN_W = (MIN_PULSE > 1) ? $clog2(MIN_PULSE) : 1;
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(MIN_PULSE - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [RUN_W-1:0]       run;
  logic                   s;

  assign s = sync[SYNC_STAGES-1];

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values and simulation matches the synthesized netlist.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      sync       <= '0;
      run        <= '0;
      level      <= 1'b0;
      edge_pulse <= 1'b0;
    end else begin
      sync       <= {sync[SYNC_STAGES-2:0], blink_in};
      edge_pulse <= 1'b0;
      if (s != level) begin
        // The level toggles on the MIN_PULSE-th consecutive differing cycle.
        if (run == RUN_LAST) begin
          level      <= ~level;
          edge_pulse <= 1'b1;
          run        <= '0;
        end else begin
          run <= run + RUN_W'(1);
        end
      end else begin
        run <= '0;
      end
    end
  end

endmodule

// File: rtl/blink_rate_meter.sv
// Measures the half-period of a filtered blink signal, classifies it as fast
// or slow, counts edges and flags a stalled input.
module blink_rate_meter
  import blink_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_PULSE   = 4,
  parameter int FAST_MAX    = FAST_MAX_DEF,
  parameter int TIMEOUT     = TIMEOUT_DEF
) (
  input  logic             CLOCK_50,
  input  logic             RESET,
  input  logic             blink_in,
  output logic [CNT_W-1:0] half_period,
  output logic             period_valid,
  output logic             is_fast,
  output logic             stalled,
  output logic [15:0]      edge_count
);

  localparam logic [CNT_W-1:0] TIMEOUT_V  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] FAST_MAX_V = CNT_W'(FAST_MAX);

  logic             level;
  logic             e;
  logic [CNT_W-1:0] cnt;
  state_t           state, state_next;
  logic             capture, enter_stall, leave_stall;

  blink_edge_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .MIN_PULSE  (MIN_PULSE)
  ) u_filter (
    .CLOCK_50  (CLOCK_50),
    .RESET     (RESET),
    .blink_in  (blink_in),
    .level     (level),
    .edge_pulse(e)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_next  = state;
    capture     = 1'b0;
    enter_stall = 1'b0;
    leave_stall = 1'b0;
    case (state)
      IDLE: begin
        if (e) state_next = MEASURE;
      end
      MEASURE: begin
        // An edge arriving on the timeout cycle is still a valid interval.
        if (e) begin
          capture = 1'b1;
        end else if (cnt == TIMEOUT_V) begin
          enter_stall = 1'b1;
          state_next  = STALL;
        end
      end
      STALL: begin
        if (e) begin
          leave_stall = 1'b1;
          state_next  = MEASURE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state        <= IDLE;
      cnt          <= '0;
      half_period  <= '0;
      period_valid <= 1'b0;
      is_fast      <= 1'b0;
      stalled      <= 1'b0;
      edge_count   <= '0;
    end else begin
      state        <= state_next;
      period_valid <= capture;

      if (e)                     cnt <= CNT_W'(1);
      else if (cnt != TIMEOUT_V) cnt <= cnt + CNT_W'(1);

      if (e && edge_count != 16'hFFFF) edge_count <= edge_count + 16'd1;

      if (capture) begin
        half_period <= cnt;
        is_fast     <= (cnt <= FAST_MAX_V);
      end
      if (enter_stall) begin
        stalled <= 1'b1;
        is_fast <= 1'b0;
      end
      if (leave_stall) stalled <= 1'b0;
    end
  end

endmodule
